// File: rtl/control_unit16.sv
// Multicycle control unit for the 16-bit processor: fetch, decode and
// sequencing of the register file, ALU, data memory and writeback mux.
module control_unit16 #(
    parameter int PC_WIDTH    = 7,
    parameter int DADDR_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [15:0]            instr,
    input  logic [15:0]            rf_rdDataA,
    output logic [PC_WIDTH-1:0]    pc_addr,
    output logic [DADDR_WIDTH-1:0] d_addr,
    output logic                   d_wr,
    output logic [1:0]             rf_sel,
    output logic [7:0]             rf_imm,
    output logic [3:0]             rf_wrAddr,
    output logic                   rf_write,
    output logic [3:0]             rf_rdAddrA,
    output logic [3:0]             rf_rdAddrB,
    output logic [1:0]             alu_sel,
    output logic                   halted
);

    localparam logic [3:0] OP_LOAD  = 4'd1;
    localparam logic [3:0] OP_STORE = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_LDI   = 4'd5;
    localparam logic [3:0] OP_JZ    = 4'd6;
    localparam logic [3:0] OP_HALT  = 4'd7;

    localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_READ   = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    state_t              state_r;
    logic [PC_WIDTH-1:0] pc_r;
    logic [15:0]         ir_r;

    logic [3:0] op_s;
    logic [3:0] ra_s;
    logic [3:0] rb_s;
    logic [3:0] rc_s;
    logic [7:0] k8_s;
    logic       in_op_s;

    // Branch offset: sign-extend k8, then keep the PC-width low bits so it wraps.
    function automatic logic [PC_WIDTH-1:0] sext_k8(input logic [7:0] k);
        return PC_WIDTH'({{8{k[7]}}, k});
    endfunction

    assign op_s    = ir_r[15:12];
    assign ra_s    = ir_r[11:8];
    assign rb_s    = ir_r[7:4];
    assign rc_s    = ir_r[3:0];
    assign k8_s    = ir_r[7:0];
    assign in_op_s = (state_r == ST_READ) || (state_r == ST_EXEC) || (state_r == ST_WB);
    assign pc_addr = pc_r;

    // Instruction sequencer: state, program counter and instruction register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_FETCH;
            pc_r    <= '0;
            ir_r    <= 16'h0000;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    state_r <= ST_DECODE;
                end
                ST_DECODE: begin
                    ir_r    <= instr;
                    pc_r    <= pc_r + PC_ONE;
                    state_r <= (instr[15:12] == OP_HALT) ? ST_HALT : ST_READ;
                end
                ST_READ: begin
                    state_r <= ST_EXEC;
                end
                ST_EXEC: begin
                    // rf_rdDataA now carries R[ra] addressed during READ.
                    if ((op_s == OP_JZ) && (rf_rdDataA == 16'h0000)) begin
                        pc_r <= pc_r + sext_k8(k8_s);
                    end
                    state_r <= ST_WB;
                end
                ST_WB: begin
                    state_r <= ST_FETCH;
                end
                ST_HALT: begin
                    state_r <= ST_HALT;
                end
                default: begin
                    state_r <= ST_FETCH;
                end
            endcase
        end
    end

    // Datapath control decode from the current state and instruction register.
    always_comb begin
        d_addr     = '0;
        d_wr       = 1'b0;
        rf_sel     = 2'd0;
        rf_imm     = 8'h00;
        rf_wrAddr  = 4'd0;
        rf_write   = 1'b0;
        rf_rdAddrA = 4'd0;
        rf_rdAddrB = 4'd0;
        alu_sel    = 2'd0;
        halted     = 1'b0;

        // Read addresses, d_addr and alu_sel stay stable from READ through WB.
        if (in_op_s) begin
            case (op_s)
                OP_LOAD: begin
                    d_addr = DADDR_WIDTH'(k8_s);
                end
                OP_STORE: begin
                    rf_rdAddrA = ra_s;
                    d_addr     = DADDR_WIDTH'(k8_s);
                end
                OP_ADD: begin
                    rf_rdAddrA = rb_s;
                    rf_rdAddrB = rc_s;
                    alu_sel    = 2'd1;
                end
                OP_SUB: begin
                    rf_rdAddrA = rb_s;
                    rf_rdAddrB = rc_s;
                    alu_sel    = 2'd2;
                end
                OP_JZ: begin
                    rf_rdAddrA = ra_s;
                end
                default: begin
                    alu_sel = 2'd0;
                end
            endcase
        end else begin
            halted = (state_r == ST_HALT);
        end

        if ((state_r == ST_EXEC) && (op_s == OP_STORE)) begin
            d_wr = 1'b1;
        end else begin
            d_wr = 1'b0;
        end

        // Writeback only in WB, so the register file never reads and writes at once.
        if (state_r == ST_WB) begin
            case (op_s)
                OP_LOAD: begin
                    rf_write  = 1'b1;
                    rf_sel    = 2'd1;
                    rf_wrAddr = ra_s;
                end
                OP_ADD, OP_SUB: begin
                    rf_write  = 1'b1;
                    rf_sel    = 2'd0;
                    rf_wrAddr = ra_s;
                end
                OP_LDI: begin
                    rf_write  = 1'b1;
                    rf_sel    = 2'd2;
                    rf_imm    = k8_s;
                    rf_wrAddr = ra_s;
                end
                default: begin
                    rf_write = 1'b0;
                end
            endcase
        end else begin
            rf_write = 1'b0;
        end
    end

endmodule

// File: tb/tb_control_unit16.sv
// Bench for control_unit16: instruction/data memory and register file attached,
// outputs compared every cycle against an instruction-level reference model.
module tb_control_unit16;

    typedef logic [41:0] vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr;
    logic [15:0] rf_rdDataA;
    logic [6:0]  pc_addr;
    logic [7:0]  d_addr;
    logic        d_wr;
    logic [1:0]  rf_sel;
    logic [7:0]  rf_imm;
    logic [3:0]  rf_wrAddr;
    logic        rf_write;
    logic [3:0]  rf_rdAddrA;
    logic [3:0]  rf_rdAddrB;
    logic [1:0]  alu_sel;
    logic        halted;

    always #5 clk = ~clk;

    control_unit16 #(.PC_WIDTH(7), .DADDR_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .instr(instr), .rf_rdDataA(rf_rdDataA),
        .pc_addr(pc_addr), .d_addr(d_addr), .d_wr(d_wr), .rf_sel(rf_sel),
        .rf_imm(rf_imm), .rf_wrAddr(rf_wrAddr), .rf_write(rf_write),
        .rf_rdAddrA(rf_rdAddrA), .rf_rdAddrB(rf_rdAddrB), .alu_sel(alu_sel),
        .halted(halted)
    );

    // Environment: memories, register file with one-cycle read, ALU and writeback mux
    logic [15:0] imem [0:127];
    logic [15:0] rf   [0:15]  = '{default: 16'h0000};
    logic [15:0] dm   [0:255] = '{default: 16'h0000};
    logic [15:0] rda_q = 16'h0000, rdb_q = 16'h0000, dq = 16'h0000;
    logic [15:0] alu_y, wb_data;

    assign rf_rdDataA = rda_q;

    always_comb begin
        case (alu_sel)
            2'd1:    alu_y = rda_q + rdb_q;
            2'd2:    alu_y = rda_q - rdb_q;
            default: alu_y = rda_q;
        endcase
        case (rf_sel)
            2'd1:    wb_data = dq;
            2'd2:    wb_data = {{8{rf_imm[7]}}, rf_imm};
            default: wb_data = alu_y;
        endcase
    end

    always @(posedge clk) begin
        instr <= imem[pc_addr];
        dq    <= dm[d_addr];
        if (rf_write) rf[rf_wrAddr] <= wb_data;
        else begin
            rda_q <= rf[rf_rdAddrA];
            rdb_q <= rf[rf_rdAddrB];
        end
        if (d_wr) dm[d_addr] <= rda_q;
    end

    // Trace recorders: cycle count since reset, visited PCs, write pulses, wrap event
    int run_id = 0;
    int cyc = 0;
    int seen [0:127] = '{default: -1};
    int wrap_run = -1;
    int wlog [$];
    logic [6:0] prev_pc = 7'd0;

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (!reset) begin
            seen[pc_addr] <= run_id;
            if (prev_pc == 7'd127 && pc_addr == 7'd0) wrap_run <= run_id;
            if (rf_write) wlog.push_back(run_id * 4096 + cyc + 1);
            prev_pc <= pc_addr;
        end
    end

    // Reference model: architectural state and expected per-cycle output vectors
    logic [6:0]  mpc;
    logic [15:0] mrf [0:15]  = '{default: 16'h0000};
    logic [15:0] mdm [0:255] = '{default: 16'h0000};
    vec_t exp_q [$];
    vec_t act_s;
    int checks = 0;
    int errors = 0;

    assign act_s = {pc_addr, d_addr, d_wr, rf_sel, rf_imm, rf_wrAddr, rf_write,
                    rf_rdAddrA, rf_rdAddrB, alu_sel, halted};

    function automatic vec_t mk(logic [6:0] pc, logic [7:0] da, logic dw, logic [1:0] sel,
                                logic [7:0] imm, logic [3:0] wa, logic we, logic [3:0] ra,
                                logic [3:0] rb, logic [1:0] alu, logic h);
        return {pc, da, dw, sel, imm, wa, we, ra, rb, alu, h};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_run(input int n, input int hold);
        logic [15:0] w;
        logic [3:0] op, ra, rb, rc, rda, rdb;
        logic [7:0] k8, da, imm;
        logic [6:0] npc, tgt;
        logic [1:0] alu, sel;
        logic we;
        for (int i = 0; i < n; i++) begin
            w = imem[mpc];
            op = w[15:12]; ra = w[11:8]; rb = w[7:4]; rc = w[3:0]; k8 = w[7:0];
            npc = mpc + 7'd1;
            exp_q.push_back(mk(mpc, 8'h00, 1'b0, 2'd0, 8'h00, 4'd0, 1'b0, 4'd0, 4'd0, 2'd0, 1'b0));
            exp_q.push_back(mk(mpc, 8'h00, 1'b0, 2'd0, 8'h00, 4'd0, 1'b0, 4'd0, 4'd0, 2'd0, 1'b0));
            if (op == 4'd7) begin
                for (int j = 0; j < hold; j++)
                    exp_q.push_back(mk(npc, 8'h00, 1'b0, 2'd0, 8'h00, 4'd0, 1'b0, 4'd0, 4'd0, 2'd0, 1'b1));
                mpc = npc;
                break;
            end
            da  = (op == 4'd1 || op == 4'd2) ? k8 : 8'h00;
            rda = (op == 4'd3 || op == 4'd4) ? rb : ((op == 4'd2 || op == 4'd6) ? ra : 4'd0);
            rdb = (op == 4'd3 || op == 4'd4) ? rc : 4'd0;
            alu = (op == 4'd3) ? 2'd1 : ((op == 4'd4) ? 2'd2 : 2'd0);
            we  = (op == 4'd1 || op == 4'd3 || op == 4'd4 || op == 4'd5);
            sel = (op == 4'd1) ? 2'd1 : ((op == 4'd5) ? 2'd2 : 2'd0);
            imm = (op == 4'd5) ? k8 : 8'h00;
            tgt = (op == 4'd6 && mrf[ra] == 16'h0000) ? npc + k8[6:0] : npc;
            exp_q.push_back(mk(npc, da, 1'b0, 2'd0, 8'h00, 4'd0, 1'b0, rda, rdb, alu, 1'b0));
            exp_q.push_back(mk(npc, da, op == 4'd2, 2'd0, 8'h00, 4'd0, 1'b0, rda, rdb, alu, 1'b0));
            exp_q.push_back(mk(tgt, da, 1'b0, sel, imm, we ? ra : 4'd0, we, rda, rdb, alu, 1'b0));
            case (op)
                4'd1: mrf[ra] = mdm[k8];
                4'd2: mdm[k8] = mrf[ra];
                4'd3: mrf[ra] = mrf[rb] + mrf[rc];
                4'd4: mrf[ra] = mrf[rb] - mrf[rc];
                4'd5: mrf[ra] = {{8{k8[7]}}, k8};
                default: ;
            endcase
            mpc = tgt;
        end
    endtask

    task automatic drain();
        vec_t e;
        int n = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            chk($sformatf("run%0d_cycle%0d_vec", run_id, n), act_s, e);
            n++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        run_id++;
        mpc = 7'd0;
    endtask

    task automatic chk_regs();
        for (int r = 0; r < 16; r++) chk($sformatf("rf%0d_vs_model", r), rf[r], mrf[r]);
    endtask

    initial begin
        int wc [$];
        reset = 1'b1;
        for (int a = 0; a < 128; a++) imem[a] = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_pc", pc_addr, 7'd0);
        chk("reset_strobes", {rf_write, d_wr, halted}, 3'b000);
        chk("reset_others", {d_addr, rf_sel, rf_imm, rf_wrAddr, rf_rdAddrA, rf_rdAddrB, alu_sel}, 32'h0);

        // Reset for two edges in the middle of an ADD's EXEC
        imem[0] = 16'h3312;
        @(posedge clk); #1; reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("add_exec_ctl", {pc_addr, rf_rdAddrA, rf_rdAddrB, alu_sel, rf_write}, {7'd1, 4'd1, 4'd2, 2'd1, 1'b0});
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("midreset_pc", pc_addr, 7'd0);
        chk("midreset_strobes", {rf_write, d_wr, halted, alu_sel}, 5'b00000);
        chk("midreset_no_wb", wlog.size(), 0);

        // Run 1: LDI, LDI, ADD, STORE, LOAD, SUB, HALT
        imem[0] = 16'h5105; imem[1] = 16'h52FD; imem[2] = 16'h3312; imem[3] = 16'h2140;
        imem[4] = 16'h1740; imem[5] = 16'h4512; imem[6] = 16'h7000;
        do_reset();
        model_run(7, 20);
        drain();
        chk("halt_state", {halted, pc_addr}, {1'b1, 7'd7});
        @(posedge clk);
        foreach (wlog[i]) if (wlog[i] / 4096 == 1) wc.push_back(wlog[i] % 4096);
        chk("wr_pulse_count", wc.size(), 5);
        chk("wr_pulse_0", wc.size() > 0 ? wc[0] : -1, 5);
        chk("wr_pulse_1", wc.size() > 1 ? wc[1] : -1, 10);
        chk("wr_pulse_2", wc.size() > 2 ? wc[2] : -1, 15);
        chk("r1", rf[1], 16'h0005);
        chk("r2", rf[2], 16'hFFFD);
        chk("r3_add", rf[3], 16'h0002);
        chk("dm40_store", dm[8'h40], 16'h0005);
        chk("r7_load", rf[7], 16'h0005);
        chk("r5_sub", rf[5], 16'h0008);
        chk_regs();

        // Run 2: JZ taken at PC 10 (+3 -> 14), JZ not taken at PC 15
        for (int a = 0; a < 128; a++) imem[a] = 16'h0000;
        imem[0] = 16'h5400; imem[2] = 16'h8123; imem[3] = 16'h9FFF; imem[4] = 16'hA000;
        imem[5] = 16'hB0C0; imem[6] = 16'hC111; imem[7] = 16'hD222; imem[8] = 16'hE333;
        imem[9] = 16'hF444; imem[10] = 16'h6403; imem[14] = 16'h5401; imem[15] = 16'h6403;
        do_reset();
        model_run(14, 0);
        drain();
        chk("jz_taken_pc14", seen[14], 2);
        chk("jz_taken_skip12", seen[12] == 2, 1'b0);
        chk("jz_nottaken_pc17", seen[17], 2);
        chk("r4_one", rf[4], 16'h0001);
        chk_regs();

        // Run 3: JZ -12 at PC 2 wraps to 119, opcode 8..15 NOOPs, PC 127 wraps to 0
        for (int a = 0; a < 128; a++) imem[a] = 16'h0000;
        imem[0] = 16'h5400; imem[2] = 16'h64F4;
        for (int a = 119; a < 127; a++) imem[a] = 16'h8000 + 16'(a - 119) * 16'h1000 + 16'h0A5;
        imem[127] = 16'hF0F0;
        do_reset();
        model_run(13, 0);
        drain();
        @(posedge clk);
        chk("jz_back_pc119", seen[119], 3);
        chk("jz_back_skip118", seen[118] == 3, 1'b0);
        chk("pc_wrap_127_0", wrap_run, 3);
        chk_regs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
